// File: rtl/sfx_pkg.sv
// Shared types, note pitches and the default sound-effect table for the sequencer.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package sfx_pkg;

    localparam int HP_W           = 17;
    localparam int MAX_EVENTS     = 4;
    localparam int MAX_NOTES      = 4;
    localparam int DEFAULT_CLK_HZ = 25_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } sfxState_t;

    // Indexed [event][note]; each entry is a tone half-period in clocks, 0 = rest.
    typedef logic [MAX_EVENTS-1:0][MAX_NOTES-1:0][HP_W-1:0] sfxTable_t;

    localparam int C4_HZ = 262;
    localparam int E4_HZ = 330;
    localparam int G4_HZ = 392;
    localparam int C5_HZ = 523;
    localparam int E5_HZ = 659;
    localparam int G5_HZ = 784;
    localparam int A5_HZ = 880;
    localparam int C6_HZ = 1047;

    localparam logic [HP_W-1:0] REST = '0;

    function automatic logic [HP_W-1:0] calcHalfPeriod(input int clkHz, input int freqHz);
        return HP_W'(clkHz / (2 * freqHz));
    endfunction

    // Concatenations list note 3 first, so the rightmost entry plays first.
    function automatic sfxTable_t sfxTable(input int clkHz);
        sfxTable_t t;
        // jump: quick rising arpeggio
        t[0] = {calcHalfPeriod(clkHz, C6_HZ), calcHalfPeriod(clkHz, G5_HZ),
                calcHalfPeriod(clkHz, E5_HZ), calcHalfPeriod(clkHz, C5_HZ)};
        // squash: falling thud ending in silence
        t[1] = {REST, calcHalfPeriod(clkHz, C4_HZ),
                calcHalfPeriod(clkHz, E4_HZ), calcHalfPeriod(clkHz, G4_HZ)};
        // score: two high blips separated by a rest
        t[2] = {REST, calcHalfPeriod(clkHz, C6_HZ),
                REST, calcHalfPeriod(clkHz, A5_HZ)};
        // level-up: climbing fanfare
        t[3] = {calcHalfPeriod(clkHz, C6_HZ), calcHalfPeriod(clkHz, A5_HZ),
                calcHalfPeriod(clkHz, G5_HZ), calcHalfPeriod(clkHz, E5_HZ)};
        return t;
    endfunction

    localparam sfxTable_t SFX_TABLE = sfxTable(DEFAULT_CLK_HZ);

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: half-period counter plus toggle flop, registered output.
// Latency: wave reflects restart/mute one clock after they are presented.
// Backpressure: none; mute only gates the output, the phase keeps running.
module sfx_tone_gen
    import sfx_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic [HP_W-1:0] halfPeriod,
    input  logic            restart,
    input  logic            enable,
    input  logic            mute,
    output logic            wave
);

    logic [HP_W-1:0] cnt;
    logic [HP_W-1:0] cntNext;
    logic            phase;
    logic            phaseNext;
    logic            waveNext;
    logic            audible;

    assign audible = (halfPeriod != '0) && !mute;

    // Restart starts a fresh high phase; a rest holds the counter at 0 so it never wraps.
    always_comb begin
        cntNext   = '0;
        phaseNext = 1'b0;
        waveNext  = 1'b0;
        if (restart) begin
            phaseNext = 1'b1;
            waveNext  = audible;
        end else if (enable) begin
            phaseNext = phase;
            if (halfPeriod != '0) begin
                if (cnt == halfPeriod - HP_W'(1)) begin
                    phaseNext = ~phase;
                end else begin
                    cntNext = cnt + HP_W'(1);
                end
            end
            waveNext = phaseNext && audible;
        end
    end

    // Counter, phase and output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b0;
            wave  <= 1'b0;
        end else begin
            cnt   <= cntNext;
            phase <= phaseNext;
            wave  <= waveNext;
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Priority sound-effect sequencer: plays a fixed note sequence per trigger edge.
// Latency: sound_out responds one clock after the cycle a trigger rise is seen.
// Backpressure: none; rises on lower-priority effects while busy are dropped.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int CLK_HZ      = 25_000_000,
    parameter int NUM_EVENTS  = 4,
    parameter int NUM_NOTES   = 4,
    parameter int NOTE_CYCLES = 3_125_000,
    parameter int GAP_CYCLES  = 250_000,
    parameter logic [NUM_EVENTS-1:0][NUM_NOTES-1:0][HP_W-1:0] NOTE_TABLE = sfxTable(CLK_HZ)
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic [NUM_EVENTS-1:0]                           trig,
    input  logic                                            mute,
    output logic                                            sound_out,
    output logic                                            busy,
    output logic [((NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1)-1:0] active_evt,
    output logic [((NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1)-1:0]   note_idx
);

    localparam int EW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam int NW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
    localparam int TW = $clog2(((NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES) + 1);
    localparam logic [TW-1:0] NOTE_LAST     = TW'(NOTE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST      = TW'(GAP_CYCLES - 1);
    localparam logic [NW-1:0] NOTE_IDX_LAST = NW'(NUM_NOTES - 1);

    sfxState_t             state;
    sfxState_t             stateNext;
    logic [NUM_EVENTS-1:0] trigQ;
    logic [NUM_EVENTS-1:0] rise;
    logic                  armed;
    logic                  anyRise;
    logic                  accept;
    logic                  noteEnd;
    logic                  gapEnd;
    logic [EW-1:0]         selEvt;
    logic [EW-1:0]         activeEvt;
    logic [EW-1:0]         evtNext;
    logic [NW-1:0]         noteIdx;
    logic [NW-1:0]         noteNext;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timerNext;
    logic                  toneRestart;
    logic                  toneEnable;
    logic [HP_W-1:0]       toneHp;

    // Trigger history; armed stays low for the first clock so a level held through reset is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trigQ <= '0;
            armed <= 1'b0;
        end else begin
            trigQ <= trig;
            armed <= 1'b1;
        end
    end

    // Edge detect and lowest-index selection.
    always_comb begin
        rise    = trig & ~trigQ & {NUM_EVENTS{armed}};
        anyRise = |rise;
        selEvt  = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (rise[i]) selEvt = EW'(i);
        end
    end

    assign accept  = anyRise && ((state == IDLE) || (selEvt <= activeEvt));
    assign noteEnd = (state == PLAY) && (timer == NOTE_LAST);
    assign gapEnd  = (state == GAP) && (timer == GAP_LAST);

    // Next-state logic; an accepted trigger overrides any terminal-count transition.
    always_comb begin
        stateNext   = state;
        evtNext     = activeEvt;
        noteNext    = noteIdx;
        timerNext   = '0;
        toneRestart = 1'b0;
        toneEnable  = 1'b0;
        if (accept) begin
            stateNext   = PLAY;
            evtNext     = selEvt;
            noteNext    = '0;
            toneRestart = 1'b1;
        end else begin
            case (state)
                PLAY: begin
                    if (noteEnd) begin
                        if (noteIdx == NOTE_IDX_LAST) begin
                            stateNext = IDLE;
                            noteNext  = '0;
                        end else begin
                            stateNext = GAP;
                        end
                    end else begin
                        timerNext  = timer + TW'(1);
                        toneEnable = 1'b1;
                    end
                end
                GAP: begin
                    if (gapEnd) begin
                        stateNext   = PLAY;
                        noteNext    = noteIdx + NW'(1);
                        toneRestart = 1'b1;
                    end else begin
                        timerNext = timer + TW'(1);
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            activeEvt <= '0;
            noteIdx   <= '0;
            timer     <= '0;
        end else begin
            state     <= stateNext;
            activeEvt <= evtNext;
            noteIdx   <= noteNext;
            timer     <= timerNext;
        end
    end

    // On a restart the tone generator needs the pitch of the note about to start.
    assign toneHp = toneRestart ? NOTE_TABLE[evtNext][noteNext] : NOTE_TABLE[activeEvt][noteIdx];

    sfx_tone_gen u_toneGen (
        .clk        (clk),
        .reset_n    (reset_n),
        .halfPeriod (toneHp),
        .restart    (toneRestart),
        .enable     (toneEnable),
        .mute       (mute),
        .wave       (sound_out)
    );

    assign busy       = (state != IDLE);
    assign active_evt = activeEvt;
    assign note_idx   = noteIdx;

endmodule

// File: doc/sfx_sequencer.md
SFX_SEQUENCER -- requirements
Module: sfx_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 25_000_000, system clock frequency, used only to derive package note constants.
REQ-002 Parameter NUM_EVENTS, default 4, number of independent sound-effect triggers (e.g. jump, squash, score, level-up).
REQ-003 Parameter NUM_NOTES, default 4, notes per effect sequence.
REQ-004 Parameter NOTE_CYCLES, default 3_125_000, note duration in clocks (125 ms).
REQ-005 Parameter GAP_CYCLES, default 250_000, silent gap between notes in clocks (10 ms).
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 reset_n  input  1  reset; asynchronous, active-low.
REQ-008 trig  input  NUM_EVENTS  level trigger per effect; bit 0 highest priority.
REQ-009 mute  input  1  forces silence; sequencing continues.
REQ-010 sound_out  output  1  registered square-wave audio.
REQ-011 busy  output  1  high while state is PLAY or GAP.
REQ-012 active_evt  output  $clog2(NUM_EVENTS)  index of the effect playing.
REQ-013 note_idx  output  $clog2(NUM_NOTES)  index of current note.

Function
REQ-014 trig is registered each cycle; rise[i] = trig[i] & ~trig_q[i]; a held-high trigger never retriggers.
REQ-015 States: IDLE, PLAY, GAP.
REQ-016 Acceptance: in IDLE, any rise selects the lowest-index rising bit; in PLAY/GAP, a rise on an index <= active_evt preempts; rises on higher indices are dropped, never queued.
REQ-017 Acceptance in cycle N: state PLAY, active_evt = selected index, note_idx = 0, note timer = 0, tone counter = 0 from cycle N+1; sound_out high in N+1 unless the note is a rest or mute is high.
REQ-018 Note half-period HP = SFX_TABLE[active_evt][note_idx] (17-bit cycles); HP = 0 denotes a rest (sound_out low for the whole note).
REQ-019 Tone: counter counts 0..HP-1; when it equals HP-1, sound_out toggles and counter returns to 0, giving period 2*HP clocks.
REQ-020 Note timer counts 0..NOTE_CYCLES-1 in PLAY; at NOTE_CYCLES-1, next state is GAP if note_idx < NUM_NOTES-1, else IDLE.
REQ-021 GAP: sound_out low, gap timer counts 0..GAP_CYCLES-1; at terminal count, PLAY with note_idx+1, tone counter 0, sound_out high (non-rest).
REQ-022 Returning to IDLE drives sound_out low, busy low, note_idx 0; active_evt holds its last value.
REQ-023 Acceptance in the same cycle as a note/gap terminal count wins over the terminal transition.
REQ-024 mute high: sound_out 0 next cycle; all counters and states advance unchanged; mute low resumes current phase of the tone.
REQ-025 Timers sized $clog2(max(NOTE_CYCLES,GAP_CYCLES)+1) bits; no counter wraps except by the explicit resets above.

Reset
REQ-026 reset_n low asynchronously forces IDLE, sound_out 0, busy 0, active_evt 0, note_idx 0, all counters 0, trig_q 0, mid-sequence included.
REQ-027 A trigger already high when reset_n deasserts is not a rise (trig_q samples it on the first clock).

Structure
REQ-028 Package sfx_pkg holds the state enum, note half-period constants (derived from CLK_HZ), and the SFX_TABLE constant array indexed [event][note].
REQ-029 Sub-module sfx_tone_gen contains the tone counter and toggle flop (inputs: half-period, restart, enable, mute; output: wave); the sequencer instantiates it once.

Verification
REQ-030 Bench uses NUM_EVENTS=2, NUM_NOTES=2, NOTE_CYCLES=100, GAP_CYCLES=10, table {{5,0},{3,4}}.
REQ-031 Pulse trig[0] at cycle N -> sound_out high N+1, toggles every 5 clocks for 100 clocks, low 10 (gap), low 100 (rest), busy drops at N+211.
REQ-032 trig[1] held high 500 cycles -> exactly one sequence: period 6 then period 8, no retrigger.
REQ-033 Play event 1, rise trig[0] at cycle 50 -> active_evt 0, note_idx 0 next cycle; rise trig[1] during event 0 -> ignored.
REQ-034 mute pulse 20 cycles mid-note -> sound_out 0 during mute; note end timing unchanged.
REQ-035 reset_n low mid-GAP -> all outputs 0 immediately (no clock edge); trig already high at release -> no playback.
